fitness_collector: RTL and testbench

Downstream consumer of the fitness evaluation pipeline. Captures the stream of per-individual total energies, writes them into one of two fitness banks (current population / offspring), and tracks the minimum-energy (best) individual of the generation. It signals generation completion to the GA controller and serves random reads to the selection stage.

---
 rtl/fitness_collector.sv | 237 +++++++++++++++++++++++
 tb/tb_fitness_collector.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fitness_collector.sv
// ============================================================================
// fitness_collector
// ----------------------------------------------------------------------------
// Purpose:
//   Receives the per-individual total energy stream from the fitness
//   evaluation pipeline and stores each value in one of two fitness banks
//   (current population or offspring). It also keeps track of the
//   minimum-energy individual of the generation. When the last individual
//   has been captured it pulses generation-complete to the GA controller.
//   A separate registered read port lets the selection stage read any bank
//   entry at any time.
//
// Parameters:
//   SELF_FIT_LENGTH  width of one energy value
//   POP_SIZE         number of individuals per generation
//   IDX_WIDTH        index width; must be at least clog2(POP_SIZE)
//
// Ports:
//   clk_i             clock
//   rst_n             asynchronous, active-low reset
//   start_i           arms collection for a new generation (used only in IDLE)
//   fit_valid_i       energy strobe from the evaluator
//   fit_energy_i      total energy of the current individual (unsigned)
//   fit_bank_i        target bank, sampled together with fit_valid_i
//   fit_done_i        evaluator's last-individual flag (used only by the
//                     optional sync check)
//   rd_bank_i         read bank select
//   rd_addr_i         read index; indices >= POP_SIZE read as zero
//   rd_data_ff_o      registered read data (the old value is returned on a
//                     read/write collision)
//   best_energy_ff_o  minimum energy seen since the last start
//   best_idx_ff_o     index of that minimum (the earliest index on ties)
//   busy_ff_o         high while collecting
//   gen_done_ff_o     one-cycle pulse when the generation is complete
//   sync_err_ff_o     sticky evaluator/collector protocol error
//
// Configuration macro:
//   FIT_COLLECT_SYNC_CHECK_EN  enables the protocol check that drives
//                              sync_err_ff_o. When the macro is undefined,
//                              fit_done_i is ignored and sync_err_ff_o is 0.
// ============================================================================
module fitness_collector #(
    parameter int SELF_FIT_LENGTH = 10,
    parameter int POP_SIZE        = 50,
    parameter int IDX_WIDTH       = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       fit_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0] fit_energy_i,
    input  logic                       fit_bank_i,
    input  logic                       fit_done_i,
    input  logic                       rd_bank_i,
    input  logic [IDX_WIDTH-1:0]       rd_addr_i,
    output logic [SELF_FIT_LENGTH-1:0] rd_data_ff_o,
    output logic [SELF_FIT_LENGTH-1:0] best_energy_ff_o,
    output logic [IDX_WIDTH-1:0]       best_idx_ff_o,
    output logic                       busy_ff_o,
    output logic                       gen_done_ff_o,
    output logic                       sync_err_ff_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(POP_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                     state_ff;
    state_t                     state_nxt;
    logic [IDX_WIDTH-1:0]       wr_ptr_ff;
    logic [SELF_FIT_LENGTH-1:0] mem_ff [2][POP_SIZE];
    logic [SELF_FIT_LENGTH-1:0] rd_word;

    logic accept_start;
    logic accept_valid;
    logic last_valid;
    logic new_best;

    // Qualified events. start_i is honoured only in IDLE, and energies are
    // accepted only while collecting. new_best uses a strict compare so that
    // on a tie the earlier individual is kept.
    always_comb begin
        accept_start = (state_ff == IDLE) && start_i;
        accept_valid = (state_ff == COLLECT) && fit_valid_i;
        last_valid   = accept_valid && (wr_ptr_ff == LAST_IDX);
        new_best     = fit_energy_i < best_energy_ff_o;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_ff <= IDLE;
        end else begin
            state_ff <= state_nxt;
        end
    end

    // Next-state logic. The collection ends on the write counter alone, so a
    // missing or misplaced fit_done_i can never stall or shorten a generation.
    always_comb begin
        state_nxt = state_ff;
        case (state_ff)
            IDLE: begin
                if (accept_start) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (last_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state. This places them
    // exactly on the cycles in which the FSM sits in COLLECT or DONE.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            busy_ff_o     <= 1'b0;
            gen_done_ff_o <= 1'b0;
        end else begin
            busy_ff_o     <= (state_nxt == COLLECT);
            gen_done_ff_o <= (state_nxt == DONE);
        end
    end

    // Write pointer. It stays at the last index after the final write, so it
    // always addresses a real entry, and it restarts only on the next start.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_ff <= '0;
        end else if (accept_start) begin
            wr_ptr_ff <= '0;
        end else if (accept_valid && !last_valid) begin
            wr_ptr_ff <= wr_ptr_ff + IDX_WIDTH'(1);
        end
    end

    // Best tracker. Start loads all ones, so any real energy below the
    // maximum wins. An energy equal to all ones leaves the initial index 0 in
    // place. The values are kept after DONE for the controller to read.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            best_energy_ff_o <= '0;
            best_idx_ff_o    <= '0;
        end else if (accept_start) begin
            best_energy_ff_o <= '1;
            best_idx_ff_o    <= '0;
        end else if (accept_valid && new_best) begin
            best_energy_ff_o <= fit_energy_i;
            best_idx_ff_o    <= wr_ptr_ff;
        end
    end

    // Fitness banks. Each entry is a separate flop word, selected by a
    // compare against the write pointer. Reset clears both banks, so an
    // aborted generation leaves no stale partial data behind.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < POP_SIZE; i++) begin
                    mem_ff[b][i] <= '0;
                end
            end
        end else if (accept_valid) begin
            for (int i = 0; i < POP_SIZE; i++) begin
                if (wr_ptr_ff == IDX_WIDTH'(i)) begin
                    mem_ff[fit_bank_i][i] <= fit_energy_i;
                end
            end
        end
    end

    // Read mux. An index outside the population matches no entry and
    // returns zero. The mux reads the current flop contents, so a write to
    // the same entry in the same cycle is seen one cycle later.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < POP_SIZE; i++) begin
            if (rd_addr_i == IDX_WIDTH'(i)) begin
                rd_word = mem_ff[rd_bank_i][i];
            end
        end
    end

    // Read data register, free-running and independent of the FSM.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_ff_o <= '0;
        end else begin
            rd_data_ff_o <= rd_word;
        end
    end

`ifdef FIT_COLLECT_SYNC_CHECK_EN
    logic sync_err_set;

    // Protocol violations. These cover a done flag before the last
    // individual, a last individual without the done flag, and any strobe
    // arriving while not collecting.
    always_comb begin
        sync_err_set = (fit_valid_i && (state_ff != COLLECT))
                     || (accept_valid && fit_done_i && (wr_ptr_ff != LAST_IDX))
                     || (last_valid && !fit_done_i);
    end

    // Sticky error flag, cleared by an accepted start. A violation in the
    // same cycle as the start takes priority, so that error is not lost.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_ff_o <= 1'b0;
        end else if (sync_err_set) begin
            sync_err_ff_o <= 1'b1;
        end else if (accept_start) begin
            sync_err_ff_o <= 1'b0;
        end
    end
`else
    logic done_unused;

    // Without the check the done flag has no function in this block.
    assign done_unused   = fit_done_i;
    assign sync_err_ff_o = 1'b0;
`endif

endmodule

// File: tb/tb_fitness_collector.sv
// ============================================================================
// tb_fitness_collector
// ----------------------------------------------------------------------------
// Scoreboard bench for fitness_collector with POP_SIZE=4 and IDX_WIDTH=3.
// The stimulus queues the expected output values together with the cycle in
// which each one is due. A monitor on the falling edge pops the due entries
// and compares them. It also matches every gen_done pulse against a queue of
// expected pulse cycles.
// ============================================================================
module tb_fitness_collector;

    localparam int W   = 10;
    localparam int POP = 4;
    localparam int IW  = 3;

`ifdef FIT_COLLECT_SYNC_CHECK_EN
    localparam int unsigned ERR_EXP = 1;
`else
    localparam int unsigned ERR_EXP = 0;
`endif

    localparam int SIG_RD   = 0;
    localparam int SIG_BE   = 1;
    localparam int SIG_BI   = 2;
    localparam int SIG_BUSY = 3;
    localparam int SIG_DONE = 4;
    localparam int SIG_ERR  = 5;

    typedef struct {
        int          due;
        int          sig;
        int unsigned exp;
        string       name;
    } chk_t;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          fit_valid_i = 1'b0;
    logic [W-1:0]  fit_energy_i = '0;
    logic          fit_bank_i = 1'b0;
    logic          fit_done_i = 1'b0;
    logic          rd_bank_i = 1'b0;
    logic [IW-1:0] rd_addr_i = '0;
    logic [W-1:0]  rd_data_ff_o;
    logic [W-1:0]  best_energy_ff_o;
    logic [IW-1:0] best_idx_ff_o;
    logic          busy_ff_o;
    logic          gen_done_ff_o;
    logic          sync_err_ff_o;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    chk_t sb[$];
    int   done_q[$];

    fitness_collector #(
        .SELF_FIT_LENGTH(W),
        .POP_SIZE       (POP),
        .IDX_WIDTH      (IW)
    ) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .fit_valid_i     (fit_valid_i),
        .fit_energy_i    (fit_energy_i),
        .fit_bank_i      (fit_bank_i),
        .fit_done_i      (fit_done_i),
        .rd_bank_i       (rd_bank_i),
        .rd_addr_i       (rd_addr_i),
        .rd_data_ff_o    (rd_data_ff_o),
        .best_energy_ff_o(best_energy_ff_o),
        .best_idx_ff_o   (best_idx_ff_o),
        .busy_ff_o       (busy_ff_o),
        .gen_done_ff_o   (gen_done_ff_o),
        .sync_err_ff_o   (sync_err_ff_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    function automatic int unsigned actualOf(input int sig);
        case (sig)
            SIG_RD:   return int'(rd_data_ff_o);
            SIG_BE:   return int'(best_energy_ff_o);
            SIG_BI:   return int'(best_idx_ff_o);
            SIG_BUSY: return int'(busy_ff_o);
            SIG_DONE: return int'(gen_done_ff_o);
            default:  return int'(sync_err_ff_o);
        endcase
    endfunction

    task automatic checkOutput(input chk_t c);
        int unsigned act;
        act = actualOf(c.sig);
        total++;
        if (act != c.exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=0x%0h want=0x%0h", c.name, cyc, act, c.exp);
        end
    endtask

    // Monitor: compares the entries that are due and matches gen_done pulses.
    always @(negedge clk_i) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end
        end
        if (gen_done_ff_o) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL gen_done_unexpected cycle=%0d got=1 want=0", cyc);
            end else begin
                int d;
                d = done_q.pop_front();
                if (d != cyc) begin
                    bad++;
                    $display("[TB] FAIL gen_done_cycle got=%0d want=%0d", cyc, d);
                end
            end
        end
    end

    task automatic expectVal(input int delay, input int sig, input int unsigned val, input string name);
        chk_t c;
        c.due  = cyc + delay;
        c.sig  = sig;
        c.exp  = val;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic expectDone();
        done_q.push_back(cyc + 1);
    endtask

    task automatic setRead(input logic b, input logic [IW-1:0] a);
        rd_bank_i = b;
        rd_addr_i = a;
    endtask

    // Drives one cycle of stimulus, then returns 1 time unit after the edge.
    task automatic applyStimulus(input logic s, input logic v, input logic [W-1:0] e,
                                 input logic b, input logic d);
        start_i      = s;
        fit_valid_i  = v;
        fit_energy_i = e;
        fit_bank_i   = b;
        fit_done_i   = d;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        fit_valid_i = 1'b0;
        fit_done_i  = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic expectAllZero(input int delay);
        expectVal(delay, SIG_RD,   0, "rst_rd_data");
        expectVal(delay, SIG_BE,   0, "rst_best_energy");
        expectVal(delay, SIG_BI,   0, "rst_best_idx");
        expectVal(delay, SIG_BUSY, 0, "rst_busy");
        expectVal(delay, SIG_DONE, 0, "rst_gen_done");
        expectVal(delay, SIG_ERR,  0, "rst_sync_err");
    endtask

    initial begin
        int unsigned t1_data [4] = '{9, 3, 7, 3};
        int unsigned t4_data [4] = '{8, 4, 6, 2};

        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset state, and an empty bank 1 read.
        expectAllZero(0);
        setRead(1'b1, 3'd2);
        expectVal(1, SIG_RD, 0, "rd_empty_bank1");
        idle();

        // Generation 1: energies 9,3,7,3 to bank 0, done on the 4th.
        expectVal(1, SIG_BUSY, 1, "t1_busy_start");
        expectVal(1, SIG_BE, 10'h3FF, "t1_best_init");
        expectVal(1, SIG_BI, 0, "t1_idx_init");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 9, "t1_best_v1");
        applyStimulus(1'b0, 1'b1, 10'd9, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 3, "t1_best_v2");
        expectVal(1, SIG_BI, 1, "t1_idx_v2");
        expectVal(1, SIG_BUSY, 1, "t1_busy_mid");
        applyStimulus(1'b0, 1'b1, 10'd3, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 3, "t1_best_v3");
        applyStimulus(1'b0, 1'b1, 10'd7, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 3, "t1_best_tie");
        expectVal(1, SIG_BI, 1, "t1_idx_tie");
        expectVal(1, SIG_BUSY, 0, "t1_busy_done");
        expectVal(1, SIG_ERR, 0, "t1_err_clean");
        expectDone();
        applyStimulus(1'b0, 1'b1, 10'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            setRead(1'b0, IW'(i));
            expectVal(1, SIG_RD, t1_data[i], "t1_read_bank0");
            idle();
        end
        setRead(1'b0, 3'd5);
        expectVal(1, SIG_RD, 0, "rd_out_of_range");
        expectVal(1, SIG_BE, 3, "t1_best_hold");
        expectVal(1, SIG_BUSY, 0, "t1_busy_idle");
        idle();

        // A strobe in IDLE is dropped.
        expectVal(1, SIG_ERR, ERR_EXP, "idle_valid_err");
        expectVal(1, SIG_BE, 3, "idle_valid_best");
        expectVal(1, SIG_BI, 1, "idle_valid_idx");
        applyStimulus(1'b0, 1'b1, 10'd5, 1'b0, 1'b0);
        setRead(1'b0, 3'd3);
        expectVal(1, SIG_RD, 3, "idle_valid_nowrite3");
        idle();
        setRead(1'b0, 3'd0);
        expectVal(1, SIG_RD, 9, "idle_valid_nowrite0");
        idle();

        // Read-before-write: bank0[1] is 3 and is overwritten with 6.
        expectVal(1, SIG_ERR, 0, "rbw_err_cleared");
        expectVal(1, SIG_BE, 10'h3FF, "rbw_best_init");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 1, "rbw_best_v1");
        expectVal(1, SIG_BI, 0, "rbw_idx_v1");
        applyStimulus(1'b0, 1'b1, 10'd1, 1'b0, 1'b0);
        setRead(1'b0, 3'd1);
        expectVal(1, SIG_RD, 3, "rbw_old_value");
        expectVal(2, SIG_RD, 6, "rbw_new_value");
        applyStimulus(1'b0, 1'b1, 10'd6, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 1, "rbw_best_v3");
        applyStimulus(1'b0, 1'b1, 10'd5, 1'b0, 1'b0);
        expectVal(1, SIG_BI, 0, "rbw_idx_final");
        expectVal(1, SIG_ERR, 0, "rbw_err_clean");
        expectDone();
        applyStimulus(1'b0, 1'b1, 10'd5, 1'b0, 1'b1);
        idle();

        // Early done flag on the 2nd of 4 valids to bank 1.
        expectVal(1, SIG_ERR, 0, "early_err_start");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 8, "early_best_v1");
        expectVal(1, SIG_ERR, 0, "early_err_v1");
        applyStimulus(1'b0, 1'b1, 10'd8, 1'b1, 1'b0);
        expectVal(1, SIG_BE, 4, "early_best_v2");
        expectVal(1, SIG_BI, 1, "early_idx_v2");
        expectVal(1, SIG_ERR, ERR_EXP, "early_err_v2");
        expectVal(1, SIG_BUSY, 1, "early_still_busy");
        applyStimulus(1'b0, 1'b1, 10'd4, 1'b1, 1'b1);
        expectVal(1, SIG_ERR, ERR_EXP, "early_err_sticky");
        applyStimulus(1'b0, 1'b1, 10'd6, 1'b1, 1'b0);
        expectVal(1, SIG_BE, 2, "early_best_v4");
        expectVal(1, SIG_BI, 3, "early_idx_v4");
        expectVal(1, SIG_BUSY, 0, "early_busy_done");
        expectDone();
        applyStimulus(1'b0, 1'b1, 10'd2, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            setRead(1'b1, IW'(i));
            expectVal(1, SIG_RD, t4_data[i], "early_read_bank1");
            idle();
        end
        setRead(1'b0, 3'd1);
        expectVal(1, SIG_RD, 6, "bank0_untouched");
        idle();

        // All-ones energies with no done flag: best stays 0x3FF at index 0.
        expectVal(1, SIG_BE, 10'h3FF, "max_best_init");
        expectVal(1, SIG_ERR, 0, "max_err_start");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expectVal(1, SIG_BE, 10'h3FF, "max_best");
            expectVal(1, SIG_BI, 0, "max_idx");
            expectVal(1, SIG_ERR, (i == 3) ? ERR_EXP : 0, "max_err_nodone");
            if (i == 3) expectDone();
            applyStimulus(1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0);
        end
        setRead(1'b0, 3'd2);
        expectVal(1, SIG_RD, 10'h3FF, "max_read");
        idle();

        // Reset in the middle of a collection.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 10'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 10'd7, 1'b1, 1'b0);
        rst_n = 1'b0;
        expectAllZero(0);
        idle();
        rst_n = 1'b1;
        setRead(1'b1, 3'd0);
        expectVal(1, SIG_RD, 0, "abort_bank1_cleared");
        expectVal(1, SIG_BUSY, 0, "abort_no_resume");
        idle();

        // Fresh generation after the abort: 2,2,1,9 to bank 0.
        expectVal(1, SIG_BUSY, 1, "fresh_busy");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 2, "fresh_best_v1");
        applyStimulus(1'b0, 1'b1, 10'd2, 1'b0, 1'b0);
        expectVal(1, SIG_BI, 0, "fresh_idx_tie");
        applyStimulus(1'b0, 1'b1, 10'd2, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 1, "fresh_best_v3");
        expectVal(1, SIG_BI, 2, "fresh_idx_v3");
        applyStimulus(1'b0, 1'b1, 10'd1, 1'b0, 1'b0);
        expectVal(1, SIG_BE, 1, "fresh_best_final");
        expectVal(1, SIG_ERR, 0, "fresh_err_clean");
        expectDone();
        applyStimulus(1'b0, 1'b1, 10'd9, 1'b0, 1'b1);
        setRead(1'b0, 3'd3);
        expectVal(1, SIG_RD, 9, "fresh_read3");
        idle();
        setRead(1'b0, 3'd1);
        expectVal(1, SIG_RD, 2, "fresh_read1");
        idle();

        repeat (3) idle();

        foreach (sb[i]) begin
            total++;
            bad++;
            $display("[TB] FAIL %s never_checked got=none want=0x%0h", sb[i].name, sb[i].exp);
        end
        foreach (done_q[i]) begin
            total++;
            bad++;
            $display("[TB] FAIL gen_done_missing got=0 want=1 at cycle %0d", done_q[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog, in case the simulation stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
